commit_trace_tx: RTL
====================

# commit_trace_tx

Transmit end of the processor's architectural commit-trace interface. Lives inside `proc_hier` beside the processor core. Each cycle it samples the core's commit signals (register write, load, store, halt), buffers them as per-cycle bundles, and serializes them as typed trace records over a valid/ready stream. The bench-side or on-chip trace consumer receives this stream. It also keeps the instruction and cycle counters that the halt record reports.

## Interface
- DEPTH, 4, bundle FIFO entries; power of two, ≥2.
- CNT_W, 32, width of the cycle and instruction counters.
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- reg_wr_en  in  1  register file write this cycle.
- reg_wr_sel  in  3  register written.
- reg_wr_data  in  16  data written.
- mem_rd, mem_wr  in  1 each  memory read / write this cycle.
- mem_addr  in  16  memory address.
- mem_wdata  in  16  store data.
- mem_rdata  in  16  load data.
- halt  in  1  halt in memory stage.
- pc, instr  in  16 each  current PC and instruction; used only under the configuration macro.
- stall  out  1  FIFO full; the core must hold its commit.
- out_valid  out  1  record available.
- out_ready  in  1  consumer accepts.
- out_type  out  3  record type: 0 REG, 1 LOAD, 2 STORE, 3 HALT, 4 PC.
- out_addr  out  16  record address field:
  - REG: {13'b0, reg_sel}
  - LOAD / STORE: mem_addr
  - HALT: cycle_cnt[15:0]
  - PC: pc
- out_data  out  16  record data field:
  - REG: reg_wr_data
  - LOAD: mem_rdata
  - STORE: mem_wdata
  - HALT: inst_cnt[15:0]
  - PC: instr
- overflow  out  1  sticky; set when a bundle was dropped.
- halted  out  1  halt record has been accepted downstream.
- cycle_cnt, inst_cnt  out  CNT_W each  free-running counters.

## Operation
- Normalization: mem_rd & mem_wr together is treated as neither. ld = mem_rd & ~mem_wr; st = mem_wr & ~mem_rd.
- Event cycle: reg_wr_en | ld | st | halt, with the block not yet frozen.
- Bundle contents: presence bits {reg, ld, st, hlt}, plus all data fields.
- Push: on an event cycle the bundle is pushed if count < DEPTH, or if count == DEPTH and a pop occurs the same edge.
- Drop: otherwise the bundle is dropped and overflow is set. Counters still update.
- cycle_cnt: +1 every edge out of reset; wraps modulo 2^CNT_W.
- inst_cnt: +1 when halt | reg_wr_en | st; wraps.
- HALT record: reports counters including the halt cycle's own increment.
- Frozen state: after a halt bundle is pushed, further event cycles are ignored (no push, no inst_cnt change) until reset. halted rises when the HALT record handshakes.
- Serializer FSM states: IDLE, PC, REG, LOAD, STORE, HALT.
  - IDLE: if FIFO non-empty, go to the first present field of the head.
  - Field order is fixed: PC, REG, LOAD, STORE, HALT.
  - On out_valid & out_ready: advance to the next present field. After the last present field, pop the head and return to IDLE, or go directly to the next head's first field if the FIFO is non-empty.
- Output hold: out_* are held stable while out_valid & ~out_ready.
- stall = (count == DEPTH), combinational from count.

## Timing
- Reset values:
  - stall, out_valid, overflow, halted = 0.
  - out_type, out_addr, out_data = 0.
  - counters = 0; FIFO empty; FSM in IDLE.
- Latency: an event sampled at edge N has its first record valid in cycle N+1 (after that edge) if the FIFO was empty.
- Throughput: one record per cycle with out_ready held high. A bundle with k records occupies k cycles.
- Load commit: a load with a register write yields REG then LOAD, on consecutive cycles.
- Reset mid-record: FIFO, FSM, and counters are cleared immediately and no partial record survives. The consumer must discard any record without a handshake.
- Full with simultaneous pop: the push succeeds and stall stays consistent with the new count on the next cycle.

## Configuration
- COMMIT_TRACE_PC_EN defined: each bundle also stores pc/instr and emits a leading PC record.
- COMMIT_TRACE_PC_EN undefined: pc/instr are ignored, no FIFO storage exists for them, and type 4 is never produced.

## Structure
- Shared package `commit_trace_pkg` holds:
  - the record-type enum (REG, LOAD, STORE, HALT, PC)
  - the bundle struct
  - the FSM state typedef
- One sub-module: `commit_trace_fifo`, a parameterized synchronous FIFO with count output, simultaneous push/pop, and async reset.

## Test plan
- reg_wr_en=1, sel=3, data=0x1234, ready=1 -> next cycle one record: type 0, addr 0x0003, data 0x1234; inst_cnt=1.
- Load, with reg_wr_en=1, sel=2, mem_rd=1, addr 0x0040, rdata 0xBEEF -> REG(2, 0xBEEF) then LOAD(0x0040, 0xBEEF) on consecutive cycles.
- mem_rd=mem_wr=1 with no reg write -> no record and inst_cnt unchanged.
- out_ready=0 with 5 store events at DEPTH=4 -> stall rises after 4; 5th dropped; overflow=1. Then ready=1 -> exactly 4 STORE records, in order.
- halt at cycle 10 after 3 committed instructions -> HALT record addr 0x000A, data 0x0004; later events produce nothing; halted=1 after the handshake.
- rst pulsed while a REG/LOAD bundle is half sent -> out_valid=0 and the counters are 0 in the same cycle; no further records.

Source files
------------

// File: rtl/commit_trace_pkg.sv
// Shared types for the commit-trace transmitter: record types, the per-cycle
// commit bundle and the serializer state encoding.
// Optional feature macro: COMMIT_TRACE_PC_EN (adds pc/instr to each bundle and
// a leading PC record).
package commit_trace_pkg;

    typedef enum logic [2:0] {
        REC_REG   = 3'd0,
        REC_LOAD  = 3'd1,
        REC_STORE = 3'd2,
        REC_HALT  = 3'd3,
        REC_PC    = 3'd4
    } rec_type_e;

    // State values follow the fixed field emission order so that "later
    // field" is a plain magnitude comparison.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PC    = 3'd1,
        ST_REG   = 3'd2,
        ST_LOAD  = 3'd3,
        ST_STORE = 3'd4,
        ST_HALT  = 3'd5
    } state_e;

    typedef struct packed {
        logic        has_reg;
        logic        has_ld;
        logic        has_st;
        logic        has_hlt;
        logic [2:0]  reg_sel;
        logic [15:0] reg_data;
        logic [15:0] mem_addr;
        logic [15:0] mem_wdata;
        logic [15:0] mem_rdata;
        logic [15:0] halt_cyc;
        logic [15:0] halt_inst;
`ifdef COMMIT_TRACE_PC_EN
        logic [15:0] pc;
        logic [15:0] instr;
`endif
    } bundle_t;

    // First present field strictly after 'cur'; ST_IDLE when none remain.
    // Checked from last to first so the earliest qualifying field wins.
    function automatic state_e next_field(bundle_t b, state_e cur);
        state_e nx;
        nx = ST_IDLE;
        if (b.has_hlt && (cur < ST_HALT))  nx = ST_HALT;
        if (b.has_st  && (cur < ST_STORE)) nx = ST_STORE;
        if (b.has_ld  && (cur < ST_LOAD))  nx = ST_LOAD;
        if (b.has_reg && (cur < ST_REG))   nx = ST_REG;
`ifdef COMMIT_TRACE_PC_EN
        if (cur < ST_PC)                   nx = ST_PC;
`endif
        return nx;
    endfunction

endpackage

// File: rtl/commit_trace_if.sv
// Valid/ready trace record stream between the transmitter (master) and the
// trace consumer (slave).
// Optional feature macro: COMMIT_TRACE_PC_EN (enables record type PC).
interface commit_trace_if;
    import commit_trace_pkg::*;

    logic        out_valid;
    logic        out_ready;
    rec_type_e   out_type;
    logic [15:0] out_addr;
    logic [15:0] out_data;

    modport master (output out_valid, output out_type, output out_addr,
                    output out_data, input out_ready);
    modport slave  (input out_valid, input out_type, input out_addr,
                    input out_data, output out_ready);
endinterface

// File: rtl/commit_trace_fifo.sv
// Parameterized synchronous FIFO with occupancy count. A push into a full
// FIFO is accepted when a pop happens on the same edge. Storage is not reset;
// only pointers and count are.
// Optional feature macro: COMMIT_TRACE_PC_EN (only affects the width W chosen
// by the parent).
module commit_trace_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           wdata,
    input  logic                   pop,
    output logic [W-1:0]           rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    // Qualify push/pop and compute next pointers and count.
    always_comb begin
        do_pop   = pop & (cnt_q != '0);
        do_push  = push & ((cnt_q != FULL_CNT) | do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state: pointers and count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = cnt_q;
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/commit_trace_tx.sv
// Commit-trace transmitter: samples commit activity into per-cycle bundles,
// buffers them, and serializes each bundle as typed records on a valid/ready
// stream. Also owns the cycle and instruction counters reported by HALT.
// Optional feature macro: COMMIT_TRACE_PC_EN (stores pc/instr per bundle and
// emits a leading PC record).
module commit_trace_tx
    import commit_trace_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 reg_wr_en,
    input  logic [2:0]           reg_wr_sel,
    input  logic [15:0]          reg_wr_data,
    input  logic                 mem_rd,
    input  logic                 mem_wr,
    input  logic [15:0]          mem_addr,
    input  logic [15:0]          mem_wdata,
    input  logic [15:0]          mem_rdata,
    input  logic                 halt,
    input  logic [15:0]          pc,
    input  logic [15:0]          instr,
    output logic                 stall,
    commit_trace_if.master       tr,
    output logic                 overflow,
    output logic                 halted,
    output logic [CNT_W-1:0]     cycle_cnt,
    output logic [CNT_W-1:0]     inst_cnt
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic             ld, st, evt, inc;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] inst_cnt_q, inst_cnt_d;
    logic             frozen_q, frozen_d;
    logic             overflow_q, overflow_d;
    logic             halted_q, halted_d;
    state_e           state_q, state_d, cur_field, nxt_field;
    bundle_t          push_b, head_b;
    logic             fifo_push, fifo_pop, fifo_empty;
    logic [CW-1:0]    fifo_count;

`ifndef COMMIT_TRACE_PC_EN
    logic unused_pc_instr;
    assign unused_pc_instr = ^{pc, instr};
`endif

    assign stall = (fifo_count == FULL_CNT);

    // Commit sampling: normalize memory ops, build the bundle, decide push/drop.
    always_comb begin
        ld  = mem_rd & ~mem_wr;
        st  = mem_wr & ~mem_rd;
        evt = (reg_wr_en | ld | st | halt) & ~frozen_q;
        inc = (halt | reg_wr_en | st) & ~frozen_q;

        cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        inst_cnt_d  = inst_cnt_q + {{(CNT_W-1){1'b0}}, inc};

        push_b           = '0;
        push_b.has_reg   = reg_wr_en;
        push_b.has_ld    = ld;
        push_b.has_st    = st;
        push_b.has_hlt   = halt;
        push_b.reg_sel   = reg_wr_sel;
        push_b.reg_data  = reg_wr_data;
        push_b.mem_addr  = mem_addr;
        push_b.mem_wdata = mem_wdata;
        push_b.mem_rdata = mem_rdata;
        // HALT reports counters including this cycle's own increment.
        push_b.halt_cyc  = cycle_cnt_d[15:0];
        push_b.halt_inst = inst_cnt_d[15:0];
`ifdef COMMIT_TRACE_PC_EN
        push_b.pc        = pc;
        push_b.instr     = instr;
`endif

        fifo_push  = evt & (~stall | fifo_pop);
        frozen_d   = frozen_q | (fifo_push & halt);
        overflow_d = overflow_q | (evt & ~fifo_push);
    end

    commit_trace_fifo #(
        .W     ($bits(bundle_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (push_b),
        .pop   (fifo_pop),
        .rdata (head_b),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    // Serializer next-state and record outputs. In IDLE with a non-empty FIFO
    // the head's first field is presented directly, so a new bundle (or the
    // next head after a pop) shows its first record without a bubble cycle.
    always_comb begin
        state_d      = state_q;
        halted_d     = halted_q;
        fifo_pop     = 1'b0;
        cur_field    = ST_IDLE;
        nxt_field    = ST_IDLE;
        tr.out_valid = 1'b0;
        tr.out_type  = REC_REG;
        tr.out_addr  = '0;
        tr.out_data  = '0;
        if (!fifo_empty) begin
            cur_field = (state_q == ST_IDLE) ? next_field(head_b, ST_IDLE) : state_q;
            nxt_field = next_field(head_b, cur_field);
            case (cur_field)
`ifdef COMMIT_TRACE_PC_EN
                ST_PC: begin
                    tr.out_valid = 1'b1;
                    tr.out_type  = REC_PC;
                    tr.out_addr  = head_b.pc;
                    tr.out_data  = head_b.instr;
                end
`endif
                ST_REG: begin
                    tr.out_valid = 1'b1;
                    tr.out_type  = REC_REG;
                    tr.out_addr  = {13'b0, head_b.reg_sel};
                    tr.out_data  = head_b.reg_data;
                end
                ST_LOAD: begin
                    tr.out_valid = 1'b1;
                    tr.out_type  = REC_LOAD;
                    tr.out_addr  = head_b.mem_addr;
                    tr.out_data  = head_b.mem_rdata;
                end
                ST_STORE: begin
                    tr.out_valid = 1'b1;
                    tr.out_type  = REC_STORE;
                    tr.out_addr  = head_b.mem_addr;
                    tr.out_data  = head_b.mem_wdata;
                end
                ST_HALT: begin
                    tr.out_valid = 1'b1;
                    tr.out_type  = REC_HALT;
                    tr.out_addr  = head_b.halt_cyc;
                    tr.out_data  = head_b.halt_inst;
                end
                default: ;
            endcase
            if (tr.out_ready) begin
                if (cur_field == ST_HALT) halted_d = 1'b1;
                if (nxt_field == ST_IDLE) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    state_d  = nxt_field;
                end
            end else begin
                state_d = cur_field;
            end
        end
    end

    // Control registers: FSM, counters and sticky flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cycle_cnt_q <= '0;
            inst_cnt_q  <= '0;
            frozen_q    <= 1'b0;
            overflow_q  <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cycle_cnt_q <= cycle_cnt_d;
            inst_cnt_q  <= inst_cnt_d;
            frozen_q    <= frozen_d;
            overflow_q  <= overflow_d;
            halted_q    <= halted_d;
        end
    end

    assign overflow  = overflow_q;
    assign halted    = halted_q;
    assign cycle_cnt = cycle_cnt_q;
    assign inst_cnt  = inst_cnt_q;

endmodule
